// File: rtl/pulse_sync_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sync_rx_if
// Description : Bundle of the per-channel crossing inputs and event outputs
//               of the pulse synchronizer receive side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pulse_sync_rx_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  logic [CH-1:0]       i_toggle_a;
  logic [CH-1:0]       i_clr;
  logic [CH-1:0]       o_level_s;
  logic [CH-1:0]       o_pulse_s;
  logic [CH*CNT_W-1:0] o_count;
  logic [CH-1:0]       o_ovf;

  // Source / consumer side: drives toggles and clears, observes events
  modport master (
    output i_toggle_a, i_clr,
    input  o_level_s, o_pulse_s, o_count, o_ovf
  );

  // Synchronizer side
  modport slave (
    input  i_toggle_a, i_clr,
    output o_level_s, o_pulse_s, o_count, o_ovf
  );
endinterface
`default_nettype wire

// File: rtl/pulse_sync_rx.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sync_rx
// Description : Multi-channel receive half of a toggle pulse synchronizer.
//               Each channel: synchronizer chain, history flop, glitch-free
//               edge detect, saturating event counter with sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_sync_rx #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int EDGE_MODE   = 0
) (
  input  wire logic      i_clk_s,
  input  wire logic      i_reset,
  pulse_sync_rx_if.slave bus
);

  logic [CH-1:0]       w_level;
  logic [CH-1:0]       w_pulse;
  logic [CH-1:0]       w_ovf;
  logic [CH*CNT_W-1:0] w_count;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    // r_sync[0] is the only flop that may go metastable; only r_sync[1] reads it
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_evt;
    logic [CNT_W-1:0]       r_count;
    logic                   r_ovf;

    // Synchronizer chain plus one history flop behind the last stage
    always_ff @(posedge i_clk_s or negedge i_reset) begin
      if (!i_reset) begin
        r_sync <= '0;
        r_hist <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_toggle_a[c]};
        r_hist <= r_sync[SYNC_STAGES-1];
      end
    end

    // Event detect uses flop outputs only, so the pulse cannot glitch
    if (EDGE_MODE == 0) begin : g_toggle
      assign w_evt = r_sync[SYNC_STAGES-1] ^ r_hist;
    end else begin : g_level
      assign w_evt = r_sync[SYNC_STAGES-1] & ~r_hist;
    end

    // Saturating event counter; a clear coinciding with an event keeps that event
    always_ff @(posedge i_clk_s or negedge i_reset) begin
      if (!i_reset) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (bus.i_clr[c]) begin
        r_count <= CNT_W'(w_evt);
        r_ovf   <= 1'b0;
      end else if (w_evt) begin
        if (&r_count) begin
          r_ovf <= 1'b1;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end

    assign w_level[c]                 = r_sync[SYNC_STAGES-1];
    assign w_pulse[c]                 = w_evt;
    assign w_ovf[c]                   = r_ovf;
    assign w_count[c*CNT_W +: CNT_W] = r_count;
  end

  assign bus.o_level_s = w_level;
  assign bus.o_pulse_s = w_pulse;
  assign bus.o_count   = w_count;
  assign bus.o_ovf     = w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pulse_sync_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_sync_rx
// Description : Two configurations of pulse_sync_rx driven by one stimulus
//               stream; expected pulses are queued per channel and matched
//               by a monitor, counters tracked by a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_sync_rx;
  localparam int CH = 4;
  localparam int W0 = 8;
  localparam int W1 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CH-1:0] tog = '0;
  logic [CH-1:0] clr = '0;

  always #5 clk = ~clk;

  pulse_sync_rx_if #(.CH(CH), .CNT_W(W0)) if0 ();
  pulse_sync_rx_if #(.CH(CH), .CNT_W(W1)) if1 ();

  assign if0.i_toggle_a = tog;
  assign if0.i_clr      = clr;
  assign if1.i_toggle_a = tog;
  assign if1.i_clr      = clr;

  // dut0: toggle mode, 2 stages, 8-bit counters
  pulse_sync_rx #(.CH(CH), .SYNC_STAGES(2), .CNT_W(W0), .EDGE_MODE(0)) dut0 (
    .i_clk_s(clk), .i_reset(rst_n), .bus(if0.slave));
  // dut1: level mode, 3 stages, 2-bit counters
  pulse_sync_rx #(.CH(CH), .SYNC_STAGES(3), .CNT_W(W1), .EDGE_MODE(1)) dut1 (
    .i_clk_s(clk), .i_reset(rst_n), .bus(if1.slave));

  logic [CH-1:0] pul_w [2];
  logic [CH-1:0] lev_w [2];
  logic [CH-1:0] ovf_w [2];
  assign pul_w[0] = if0.o_pulse_s;
  assign pul_w[1] = if1.o_pulse_s;
  assign lev_w[0] = if0.o_level_s;
  assign lev_w[1] = if1.o_level_s;
  assign ovf_w[0] = if0.o_ovf;
  assign ovf_w[1] = if1.o_ovf;

  int sync_n [2] = '{2, 3};
  int mode_n [2] = '{0, 1};
  int maxc   [2] = '{255, 3};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int exp_q [2][CH][$];
  int mcnt  [2][CH];
  bit movf  [2][CH];
  int last_tog [CH];
  bit [CH-1:0] tog_log [8192];

  function automatic int get_cnt(int d, int c);
    if (d == 0) return int'(if0.o_count[c*W0 +: W0]);
    return int'(if1.o_count[c*W1 +: W1]);
  endfunction

  task automatic check(string name, int d, int c, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s dut%0d ch%0d cyc=%0d actual=%0d required=%0d",
               name, d, c, cyc, act, req);
    end
  endtask

  // Source-side toggle: queue the pulse each configuration should produce
  task automatic do_toggle(int c);
    tog[c] = ~tog[c];
    last_tog[c] = cyc;
    for (int d = 0; d < 2; d++)
      if (mode_n[d] == 0 || tog[c] == 1'b1)
        exp_q[d][c].push_back(cyc + sync_n[d]);
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++) begin
        exp_q[d][c].delete();
        mcnt[d][c] = 0;
        movf[d][c] = 1'b0;
      end
  endtask

  // Cycle counter: value k after the k-th rising edge
  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  // Monitor and reference model, sampled on the falling edge
  initial begin
    int n;
    bit ep;
    forever begin
      @(negedge clk);
      n = cyc;
      tog_log[n % 8192] = tog;
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < CH; c++) begin
          if (!rst_n) begin
            check("rst_pulse", d, c, int'(pul_w[d][c]), 0);
            check("rst_count", d, c, get_cnt(d, c), 0);
            check("rst_ovf",   d, c, int'(ovf_w[d][c]), 0);
            check("rst_level", d, c, int'(lev_w[d][c]), 0);
          end else begin
            ep = (exp_q[d][c].size() > 0 && exp_q[d][c][0] == n);
            // Expected pulses whose cycle passed without the DUT showing them
            while (exp_q[d][c].size() > 0 && exp_q[d][c][0] < n) begin
              check("missed_pulse", d, c, n, exp_q[d][c][0]);
              void'(exp_q[d][c].pop_front());
            end
            if (pul_w[d][c]) begin
              if (exp_q[d][c].size() == 0) begin
                check("spurious_pulse", d, c, 1, 0);
              end else begin
                check("pulse_cycle", d, c, n, exp_q[d][c].pop_front());
              end
            end
            check("count", d, c, get_cnt(d, c), mcnt[d][c]);
            check("ovf", d, c, int'(ovf_w[d][c]), int'(movf[d][c]));
            if (n - sync_n[d] >= 0)
              check("level", d, c, int'(lev_w[d][c]),
                    int'(tog_log[(n - sync_n[d]) % 8192][c]));
            // Counter rules for the coming edge
            if (clr[c]) begin
              mcnt[d][c] = ep ? 1 : 0;
              movf[d][c] = 1'b0;
            end else if (ep) begin
              if (mcnt[d][c] == maxc[d]) movf[d][c] = 1'b1;
              else mcnt[d][c] = mcnt[d][c] + 1;
            end
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    for (int c = 0; c < CH; c++) last_tog[c] = -100;
    clear_model();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Single toggle on ch0
    @(posedge clk); #1 do_toggle(0);
    repeat (6) @(posedge clk);

    // Five toggles on ch1, four cycles apart
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 do_toggle(1);
      repeat (3) @(posedge clk);
    end
    repeat (4) @(posedge clk);

    // Eight toggles on ch2: saturates the 2-bit counters
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 do_toggle(2);
      repeat (4) @(posedge clk);
    end
    repeat (4) @(posedge clk);

    // Clear landing on the same edge as a dut0 pulse
    @(posedge clk); #1 do_toggle(2);
    @(posedge clk);
    @(posedge clk); #1 clr[2] = 1'b1;
    @(posedge clk); #1 clr[2] = 1'b0;
    repeat (6) @(posedge clk);

    // All channels at once
    @(posedge clk); #1 for (int c = 0; c < CH; c++) do_toggle(c);
    repeat (8) @(posedge clk);

    // Reset with an event in flight
    @(posedge clk); #1 do_toggle(3);
    @(posedge clk); #2 rst_n = 1'b0; tog = '0; clr = '0; clear_model();
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < CH; c++) last_tog[c] = cyc;
    repeat (8) @(posedge clk);

    // Randomized traffic respecting the source spacing rule
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      for (int c = 0; c < CH; c++) begin
        if (cyc - last_tog[c] >= 5 && $urandom_range(3) == 0) do_toggle(c);
        clr[c] = ($urandom_range(7) == 0);
      end
    end
    @(posedge clk); #1 clr = '0;
    repeat (10) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++)
        check("drain", d, c, exp_q[d][c].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end
endmodule
`default_nettype wire
